// File: rtl/lc3_fetch_pkg.sv
// Shared opcodes, FSM encoding and offset sign-extension helpers
// for the prefetching LC-3 fetch unit.
package lc3_fetch_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sext9(input logic [8:0] v);
        return {{23{v[8]}}, v};
    endfunction

    function automatic logic [31:0] sext11(input logic [10:0] v);
        return {{21{v[10]}}, v};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instruction} entries.
// Flush takes priority over push and pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

    // Head reads as zero when empty so stale entries never leak out.
    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch.sv
// LC-3 fetch unit with a prefetch queue, local branch redirect and a
// req/gnt/rvalid instruction memory port (one request outstanding).
module fetch_prefetch
    import lc3_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              br_valid,
    input  logic [3:0]        br_opcode,
    input  logic [11:0]       br_instr,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_base,
    input  logic [2:0]        result_nzp,
    output logic              redirect_taken,
    output logic [ADDR_W-1:0] pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic              discard_q, discard_d;
    logic              redir_q;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [31:0]       off9;
    logic [31:0]       off11;

    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occ_d;
    logic              room;
    logic [ADDR_W+DATA_W-1:0] head;

    always_comb begin
        off9     = sext9(br_instr[8:0]);
        off11    = sext11(br_instr[10:0]);
        redirect = 1'b0;
        target   = br_base;
        if (br_valid) begin
            unique case (br_opcode)
                OP_BR: begin
                    redirect = |(br_instr[11:9] & result_nzp);
                    target   = br_pc + off9[ADDR_W-1:0];
                end
                OP_JMP: begin
                    redirect = 1'b1;
                    target   = br_base;
                end
                OP_JSR: begin
                    redirect = 1'b1;
                    target   = br_instr[11] ? br_pc + off11[ADDR_W-1:0]
                                            : br_base;
                end
                default: ;
            endcase
        end
    end

    assign push = (state_q == S_WAIT) && mem_rvalid && !discard_q && !redirect;
    assign pop  = ir_valid && ir_ready;

    // Occupancy after this edge; decides whether a new slot can be reserved.
    assign occ_d = redirect ? '0 : count + CW'(push) - CW'(pop);
    assign room  = occ_d < CW'(DEPTH);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rpc_d     = rpc_q;
        discard_d = discard_q;
        mem_req   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_en && room) state_d = S_REQ;
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = S_WAIT;
                    rpc_d   = pc_q;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    discard_d = 1'b0;
                    state_d   = (fetch_en && room) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect) begin
            pc_d = target;
            unique case (state_q)
                S_REQ: begin
                    if (mem_gnt) discard_d = 1'b1;
                    else         state_d   = fetch_en ? S_REQ : S_IDLE;
                end
                S_WAIT: begin
                    if (!mem_rvalid) discard_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            rpc_q     <= RESET_PC;
            discard_q <= 1'b0;
            redir_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rpc_q     <= rpc_d;
            discard_q <= discard_d;
            redir_q   <= redirect;
        end
    end

    fetch_fifo #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(redirect),
        .data_i ({rpc_q, mem_rdata}),
        .data_o (head),
        .valid_o(ir_valid),
        .count_o(count)
    );

    assign ir_pc          = head[ADDR_W+DATA_W-1:DATA_W];
    assign ir_data        = head[DATA_W-1:0];
    assign mem_addr       = pc_q;
    assign pc             = pc_q;
    assign redirect_taken = redir_q;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a scoreboard model of the
// instruction stream and a small req/gnt/rvalid memory responder.
module tb_fetch_prefetch;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [3:0]  br_opcode = '0;
    logic [11:0] br_instr = '0;
    logic [15:0] br_pc = '0;
    logic [15:0] br_base = '0;
    logic [2:0]  result_nzp = '0;
    logic        redirect_taken;
    logic [15:0] pc;

    fetch_prefetch #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
        .ir_ready(ir_ready), .br_valid(br_valid), .br_opcode(br_opcode),
        .br_instr(br_instr), .br_pc(br_pc), .br_base(br_base),
        .result_nzp(result_nzp), .redirect_taken(redirect_taken), .pc(pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    ent_t        mq[$];
    ent_t        pop_log[$];
    logic [15:0] gnt_log[$];
    logic [15:0] mpc = '0;
    logic [15:0] out_pc = '0;
    bit          out_v = 0;
    bit          out_drop = 0;
    bit          exp_rt = 0;

    // responder state
    bit          pend = 0;
    int          pend_wait = 0;
    logic [15:0] pend_addr = '0;
    int          lat = 1;
    bit          gnt_en = 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic decode(output bit redir, output logic [15:0] tgt);
        int off;
        redir = 0;
        tgt   = '0;
        if (br_valid) begin
            if (br_opcode == 4'b0000) begin
                if ((br_instr[11:9] & result_nzp) != 3'b000) begin
                    redir = 1;
                    off = int'(br_instr[8:0]);
                    if (off > 255) off -= 512;
                    tgt = 16'(int'(br_pc) + off);
                end
            end else if (br_opcode == 4'b1100) begin
                redir = 1;
                tgt   = br_base;
            end else if (br_opcode == 4'b0100) begin
                redir = 1;
                if (br_instr[11]) begin
                    off = int'(br_instr[10:0]);
                    if (off > 1023) off -= 2048;
                    tgt = 16'(int'(br_pc) + off);
                end else begin
                    tgt = br_base;
                end
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc      = 16'h0000;
        out_v    = 0;
        out_drop = 0;
        exp_rt   = 0;
    endtask

    task automatic check_outputs();
        chk("ir_valid", ir_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("ir_pc", ir_pc, mq[0].pc);
            chk("ir_data", ir_data, mq[0].data);
        end
        chk("pc", pc, mpc);
        chk("redirect_taken", redirect_taken, exp_rt);
        chk("req_while_outstanding", mem_req && out_v, 0);
        chk("req_when_full", mem_req && (mq.size() + out_v >= DEPTH), 0);
        if (mem_req) chk("mem_addr", mem_addr, mpc);
    endtask

    task automatic model_update(input bit gnt, input bit rv,
                                input logic [15:0] rd);
        bit          redir;
        logic [15:0] tgt;
        decode(redir, tgt);
        if (redir) begin
            mq.delete();
            if (rv) out_v = 0;
            if (gnt) begin
                out_v    = 1;
                out_drop = 1;
            end else if (out_v) begin
                out_drop = 1;
            end
            mpc    = tgt;
            exp_rt = 1;
        end else begin
            exp_rt = 0;
            if (ir_ready && mq.size() != 0) begin
                pop_log.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (rv && out_v) begin
                if (!out_drop) mq.push_back('{pc: out_pc, data: rd});
                out_v    = 0;
                out_drop = 0;
            end
            if (gnt) begin
                out_v    = 1;
                out_drop = 0;
                out_pc   = mpc;
                mpc      = mpc + 16'd1;
            end
        end
    endtask

    task automatic step();
        bit          gnt;
        bit          rv;
        logic [15:0] rd;
        @(negedge clk);
        gnt = mem_req && gnt_en && !rst;
        rv  = pend && (pend_wait == 0);
        rd  = memval(pend_addr);
        if (rst) model_reset();
        else begin
            check_outputs();
            model_update(gnt, rv, rd);
        end
        if (rv) pend = 0;
        else if (pend && pend_wait > 0) pend_wait--;
        if (gnt) begin
            pend      = 1;
            pend_wait = lat - 1;
            pend_addr = mem_addr;
            gnt_log.push_back(mem_addr);
        end
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rv ? rd : 16'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pend   = 0;
        lat    = 1;
        gnt_en = 1;
        rst    = 1;
        step();
        step();
        rst = 0;
        gnt_log.delete();
        pop_log.delete();
    endtask

    task automatic branch(input logic [3:0] op, input logic [11:0] ins,
                          input logic [15:0] bpc, input logic [15:0] base,
                          input logic [2:0] nzp);
        br_valid   = 1;
        br_opcode  = op;
        br_instr   = ins;
        br_pc      = bpc;
        br_base    = base;
        result_nzp = nzp;
        step();
        br_valid = 0;
    endtask

    initial begin
        int n;
        // asynchronous reset, no clock edge yet
        #3 rst = 1;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir_data", ir_data, 16'h0000);
        chk("rst_ir_pc", ir_pc, 16'h0000);
        chk("rst_redirect", redirect_taken, 0);

        // sequential fetch, gnt same cycle, rvalid +1
        fetch_en = 1;
        ir_ready = 1;
        do_reset();
        step();
        chk("t1_first_req", mem_req, 1);
        chk("t1_first_addr", mem_addr, 16'h0000);
        repeat (9) step();
        chk("t1_ngnt", gnt_log.size(), 5);
        chk("t1_npop_ge3", pop_log.size() >= 3, 1);
        if (gnt_log.size() >= 3 && pop_log.size() >= 3) begin
            chk("t1_gnt0", gnt_log[0], 16'h0000);
            chk("t1_gnt1", gnt_log[1], 16'h0001);
            chk("t1_gnt2", gnt_log[2], 16'h0002);
            chk("t1_pop0", pop_log[0], {16'h0000, 16'hA5A5});
            chk("t1_pop1", pop_log[1], {16'h0001, 16'hA5A4});
            chk("t1_pop2", pop_log[2], {16'h0002, 16'hA5A7});
        end

        // queue full
        do_reset();
        ir_ready = 0;
        repeat (20) step();
        chk("t2_ngnt_full", gnt_log.size(), 4);
        chk("t2_req_off", mem_req, 0);
        chk("t2_head_pc", ir_pc, 16'h0000);
        ir_ready = 1;
        step();
        ir_ready = 0;
        repeat (4) step();
        chk("t2_ngnt_after_pop", gnt_log.size(), 5);

        // BR z taken from idle with full queue, then untaken
        branch(4'b0000, 12'h402, 16'h3001, 16'h0000, 3'b010);
        chk("t3_rt", redirect_taken, 1);
        chk("t3_req", mem_req, 1);
        chk("t3_addr", mem_addr, 16'h3003);
        chk("t3_flush", ir_valid, 0);
        step();
        chk("t3_rt_pulse", redirect_taken, 0);
        branch(4'b0000, 12'h402, 16'h3001, 16'h0000, 3'b100);
        chk("t3_untaken_rt", redirect_taken, 0);
        repeat (6) step();

        // JMP while a request is outstanding
        do_reset();
        ir_ready = 1;
        lat = 3;
        for (int i = 0; i < 10 && !pend; i++) step();
        chk("t4_in_wait", pend, 1);
        n = gnt_log.size();
        branch(4'b1100, 12'h000, 16'h0000, 16'h4000, 3'b000);
        for (int i = 0; i < 20 && gnt_log.size() == n; i++) step();
        chk("t4_regnt", gnt_log.size(), n + 1);
        if (gnt_log.size() > n) chk("t4_addr", gnt_log[n], 16'h4000);
        chk("t4_dropped", ir_valid, 0);
        repeat (8) step();

        // JSR offset -1 wraps below zero, then sequential wrap
        do_reset();
        ir_ready = 0;
        repeat (20) step();
        branch(4'b0100, 12'hFFF, 16'h0000, 16'h0000, 3'b000);
        chk("t5_req", mem_req, 1);
        chk("t5_addr", mem_addr, 16'hFFFF);
        n = gnt_log.size();
        repeat (4) step();
        chk("t5_ngnt", gnt_log.size(), n + 2);
        if (gnt_log.size() >= n + 2) begin
            chk("t5_gnt_ffff", gnt_log[n], 16'hFFFF);
            chk("t5_gnt_wrap", gnt_log[n+1], 16'h0000);
        end
        branch(4'b0100, 12'h000, 16'h0000, 16'h1234, 3'b000);
        chk("t5_jsrr_rt", redirect_taken, 1);
        chk("t5_jsrr_pc", pc, 16'h1234);
        repeat (8) step();

        // redirect while REQ is held without gnt
        do_reset();
        gnt_en = 0;
        ir_ready = 1;
        repeat (3) step();
        chk("t7_req_held", mem_req, 1);
        chk("t7_addr_held", mem_addr, 16'h0000);
        branch(4'b1100, 12'h000, 16'h0000, 16'h0800, 3'b000);
        chk("t7_req", mem_req, 1);
        chk("t7_addr", mem_addr, 16'h0800);
        chk("t7_rt", redirect_taken, 1);
        gnt_en = 1;
        step();
        chk("t7_gnt", gnt_log.size(), 1);
        if (gnt_log.size() >= 1) chk("t7_gnt_addr", gnt_log[0], 16'h0800);
        repeat (6) step();

        // reset mid-transaction, stray rvalid afterwards
        do_reset();
        ir_ready = 0;
        lat = 3;
        for (int i = 0; i < 30 && gnt_log.size() < 3; i++) step();
        for (int i = 0; i < 10 && !pend; i++) step();
        step();
        chk("t6_have_data", ir_valid, 1);
        rst = 1;
        #1;
        chk("t6_req", mem_req, 0);
        chk("t6_ir_valid", ir_valid, 0);
        chk("t6_pc", pc, 16'h0000);
        chk("t6_mem_addr", mem_addr, 16'h0000);
        chk("t6_rt", redirect_taken, 0);
        fetch_en = 0;
        step();
        rst = 0;
        repeat (4) step();
        chk("t6_stray_ignored", ir_valid, 0);
        fetch_en = 1;
        n = gnt_log.size();
        repeat (3) step();
        chk("t6_restart", gnt_log.size() > n, 1);
        if (gnt_log.size() > n) chk("t6_restart_addr", gnt_log[n], 16'h0000);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
